// File: rtl/serial_sub_ctrl_if.sv
// Operand/result handshake bundle for serial_sub_ctrl.
// The ovf signal exists only when SERIAL_SUB_OVF_EN is defined.
interface serial_sub_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf;

  modport master (output start, a, b, input busy, done, diff, borrow, ovf);
  modport slave  (input start, a, b, output busy, done, diff, borrow, ovf);
`else
  modport master (output start, a, b, input busy, done, diff, borrow);
  modport slave  (input start, a, b, output busy, done, diff, borrow);
`endif
endinterface

// File: rtl/serial_sub_ctrl.sv
// Bit-serial subtractor sequencer: one shared 1-bit cell computes a - b LSB first over WIDTH cycles.
// Optional feature macro: SERIAL_SUB_OVF_EN adds a registered signed-overflow output.
module serial_sub_ctrl #(
  parameter int WIDTH = 8
) (
  input logic               clk,
  input logic               rst,
  serial_sub_ctrl_if.slave  subIf
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] aSh_q;
  logic [WIDTH-1:0] bSh_q;
  logic [WIDTH-1:0] resSh_q;
  logic [WIDTH-1:0] resSh_d;
  logic [WIDTH-1:0] diff_q;
  logic [CW-1:0]    cnt_q;
  logic             borrowFf_q;
  logic             borrow_q;
  logic             busy_q;
  logic             done_q;
  logic             cellX;
  logic             cellY;
  logic             cellD;
  logic             cellBout;
  logic             lastBit;

  // The single shared one-bit subtractor cell.
  assign cellX    = aSh_q[0];
  assign cellY    = bSh_q[0];
  assign cellD    = cellX ^ cellY ^ borrowFf_q;
  assign cellBout = (~cellX & cellY) | (~(cellX ^ cellY) & borrowFf_q);
  assign resSh_d  = {cellD, resSh_q[WIDTH-1:1]};
  assign lastBit  = (cnt_q == CW'(WIDTH - 1));

`ifdef SERIAL_SUB_OVF_EN
  logic aMsb_q;
  logic bMsb_q;
  logic ovf_q;
  logic ovf_d;

  assign ovf_d     = (aMsb_q != bMsb_q) & (resSh_d[WIDTH-1] != aMsb_q);
  assign subIf.ovf = ovf_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      aSh_q      <= '0;
      bSh_q      <= '0;
      resSh_q    <= '0;
      diff_q     <= '0;
      cnt_q      <= '0;
      borrowFf_q <= 1'b0;
      borrow_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      aMsb_q     <= 1'b0;
      bMsb_q     <= 1'b0;
      ovf_q      <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (subIf.start) begin
            aSh_q      <= subIf.a;
            bSh_q      <= subIf.b;
            resSh_q    <= '0;
            borrowFf_q <= 1'b0;
            cnt_q      <= '0;
            busy_q     <= 1'b1;
            state_q    <= RUN;
`ifdef SERIAL_SUB_OVF_EN
            aMsb_q     <= subIf.a[WIDTH-1];
            bMsb_q     <= subIf.b[WIDTH-1];
`endif
          end
        end
        RUN: begin
          aSh_q      <= aSh_q >> 1;
          bSh_q      <= bSh_q >> 1;
          resSh_q    <= resSh_d;
          borrowFf_q <= cellBout;
          cnt_q      <= cnt_q + CW'(1);
          // Published results only move on the final bit so they hold through later runs.
          if (lastBit) begin
            diff_q   <= resSh_d;
            borrow_q <= cellBout;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= DONE;
`ifdef SERIAL_SUB_OVF_EN
            ovf_q    <= ovf_d;
`endif
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign subIf.busy   = busy_q;
  assign subIf.done   = done_q;
  assign subIf.diff   = diff_q;
  assign subIf.borrow = borrow_q;
endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Scoreboard bench for serial_sub_ctrl at WIDTH=8 plus a small WIDTH=2 instance.
// Overflow expectations are checked only when SERIAL_SUB_OVF_EN is defined.
module tb_serial_sub_ctrl;
  localparam int W  = 8;
  localparam int W2 = 2;

  typedef struct packed {
    logic [W-1:0] diff;
    logic         borrow;
    logic         ovf;
  } result_t;

  typedef struct packed {
    logic [W2-1:0] diff;
    logic          borrow;
    int            cyc;
  } small_t;

  logic clk = 1'b0;
  logic rst;
  logic rst2;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;
  int countdown  = 0;
  bit smallFinished = 1'b0;

  result_t expQ[$];
  result_t last;
  small_t  smallQ[$];

  serial_sub_ctrl_if #(.WIDTH(W))  subIf ();
  serial_sub_ctrl_if #(.WIDTH(W2)) smallIf ();

  serial_sub_ctrl #(.WIDTH(W))  dut      (.clk(clk), .rst(rst),  .subIf(subIf.slave));
  serial_sub_ctrl #(.WIDTH(W2)) dutSmall (.clk(clk), .rst(rst2), .subIf(smallIf.slave));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference: difference modulo 2^W, unsigned borrow, and signed range overflow.
  function automatic result_t refSub(input logic [W-1:0] a, input logic [W-1:0] b);
    result_t r;
    longint  half;
    longint  sa;
    longint  sb;
    longint  sd;
    half     = longint'(1) << (W - 1);
    sa       = (longint'(a) >= half) ? longint'(a) - 2 * half : longint'(a);
    sb       = (longint'(b) >= half) ? longint'(b) - 2 * half : longint'(b);
    sd       = sa - sb;
    r.diff   = W'(longint'(a) - longint'(b));
    r.borrow = (a < b);
    r.ovf    = (sd > half - 1) || (sd < -half);
    return r;
  endfunction

  // Protocol timing model: an accept costs W+2 cycles before the next can happen.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      expQ.delete();
      countdown = 0;
      last      = '0;
    end else if (countdown == 0) begin
      if (subIf.start) begin
        expQ.push_back(refSub(subIf.a, subIf.b));
        countdown = W + 1;
      end
    end else begin
      countdown--;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      checkOutput("busy", 64'(subIf.busy), 64'(countdown >= 2));
      checkOutput("done", 64'(subIf.done), 64'(countdown == 1));
      if (subIf.done) begin
        if (expQ.size() == 0) begin
          compared++;
          mismatched++;
          $display("[TB] FAIL unexpectedDone: got done=1, required no pending operation at %0t", $time);
        end else begin
          last = expQ.pop_front();
        end
      end
      checkOutput("diff", 64'(subIf.diff), 64'(last.diff));
      checkOutput("borrow", 64'(subIf.borrow), 64'(last.borrow));
`ifdef SERIAL_SUB_OVF_EN
      checkOutput("ovf", 64'(subIf.ovf), 64'(last.ovf));
`endif
    end
  end

  always @(negedge clk) begin
    if (!rst2 && smallIf.done) begin
      if (smallQ.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL smallUnexpectedDone: got done=1, required no pending operation at %0t", $time);
      end else begin
        small_t e;
        e = smallQ.pop_front();
        checkOutput("smallDiff", 64'(smallIf.diff), 64'(e.diff));
        checkOutput("smallBorrow", 64'(smallIf.borrow), 64'(e.borrow));
        checkOutput("smallDoneCycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    subIf.start = 1'b1;
    subIf.a     = a;
    subIf.b     = b;
    @(negedge clk);
    subIf.start = 1'b0;
    subIf.a     = W'($urandom);
    subIf.b     = W'($urandom);
    repeat (W + 2) @(negedge clk);
  endtask

  initial begin
    rst2          = 1'b1;
    smallIf.start = 1'b0;
    smallIf.a     = '0;
    smallIf.b     = '0;
    repeat (2) @(negedge clk);
    #1 rst2 = 1'b0;
    for (int i = 0; i < 9; i++) begin
      logic [W2-1:0] sa;
      logic [W2-1:0] sb;
      small_t        e;
      sa = (i == 0) ? 2'b01 : W2'($urandom);
      sb = (i == 0) ? 2'b10 : W2'($urandom);
      @(negedge clk);
      smallIf.start = 1'b1;
      smallIf.a     = sa;
      smallIf.b     = sb;
      e.diff   = W2'(int'(sa) - int'(sb));
      e.borrow = (sa < sb);
      e.cyc    = cyc + 3;
      smallQ.push_back(e);
      @(negedge clk);
      smallIf.start = 1'b0;
      smallIf.a     = W2'($urandom);
      smallIf.b     = W2'($urandom);
      repeat (3) @(negedge clk);
    end
    smallFinished = 1'b1;
  end

  initial begin
    rst         = 1'b1;
    subIf.start = 1'b0;
    subIf.a     = '0;
    subIf.b     = '0;
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;

    applyStimulus(8'd5, 8'd3);
    applyStimulus(8'h00, 8'h01);
    applyStimulus(8'hA5, 8'hA5);
    applyStimulus(8'h80, 8'h01);
    applyStimulus(8'h7F, 8'h01);
    applyStimulus(8'h7F, 8'hFF);
    for (int i = 0; i < 20; i++) applyStimulus(W'($urandom), W'($urandom));

    // Start held high with operands changing every cycle.
    @(negedge clk);
    subIf.start = 1'b1;
    for (int i = 0; i < 60; i++) begin
      subIf.a = W'($urandom);
      subIf.b = W'($urandom);
      @(negedge clk);
    end
    subIf.start = 1'b0;
    repeat (W + 3) @(negedge clk);

    // Abort a run part-way through with reset.
    @(negedge clk);
    subIf.start = 1'b1;
    subIf.a     = 8'h10;
    subIf.b     = 8'h20;
    @(negedge clk);
    subIf.start = 1'b0;
    repeat (3) @(negedge clk);
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    applyStimulus(8'd9, 8'd4);
    for (int i = 0; i < 5; i++) applyStimulus(W'($urandom), W'($urandom));

    repeat (W + 4) @(negedge clk);
    checkOutput("pendingOps", 64'(expQ.size()), 64'(0));
    checkOutput("smallFinished", 64'(smallFinished), 64'(1));
    checkOutput("smallPendingOps", 64'(smallQ.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/serial_sub_ctrl.md
# serial_sub_ctrl

Bit-serial subtractor sequencer that computes an N-bit difference A − B by reusing a single one-bit subtractor cell (difference plus borrow chain) over WIDTH clock cycles, LSB first. It accepts operands with a start/done handshake, steps a bit counter, and carries the borrow between cycles in a flip-flop. It is the sequencing layer above the team's one-bit subtractor cells, trading throughput for area where many narrow subtractions share one cell.

## Interface
- WIDTH, 8: operand and result width in bits; legal range 2..32.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  minuend; captured on the accepting edge.
- b  input  WIDTH  subtrahend; captured on the accepting edge.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse; result valid.
- diff  output  WIDTH  (a − b) mod 2^WIDTH; registered, held until next completion.
- borrow  output  1  final borrow-out; 1 iff a < b unsigned.
- ovf  output  1  signed overflow; present only with SERIAL_SUB_OVF_EN.

## Operation
- States: IDLE, RUN, DONE. Encoding is free; no other states.
- IDLE: start=1 → capture a, b into internal shift registers, clear borrow flip-flop, clear bit counter, go RUN. start=0 → stay.
- RUN: each cycle, the one-bit cell takes x=a_sh[0], y=b_sh[0], bin=borrow_ff.
  - d = x ^ y ^ bin; bout = (~x & y) | (~(x ^ y) & bin).
  - d shifts into the MSB of the result shift register; a_sh, b_sh shift right; borrow_ff ← bout; counter increments.
  - After the WIDTH-th bit: diff ← assembled result, borrow ← final bout, go DONE.
- DONE: done=1 for exactly one cycle, then IDLE unconditionally.
- start in RUN or DONE is ignored; no queuing. Changes on a/b after capture do not affect the result.
- diff/borrow/ovf change only at the transition into DONE; stable otherwise, including through the next RUN.
- Counter width $clog2(WIDTH+1); no wrap inside an operation.

## Timing
- Reset values: busy=0, done=0, diff=0, borrow=0, ovf=0; state=IDLE; internal registers 0.
- Reset asserted mid-RUN or in DONE: immediate abort to IDLE, no done pulse, outputs return to 0.
- Let E0 be the edge sampling start=1 in IDLE. busy=1 after E0 through E(WIDTH). Bits 0..WIDTH−1 are processed on E1..E(WIDTH).
- After E(WIDTH): busy=0, done=1, outputs valid. After E(WIDTH+1): done=0, state IDLE.
- Earliest next accepting edge: E(WIDTH+2). Sustained throughput: one operation per WIDTH+2 cycles.
- start asserted in the same cycle as done is not accepted. It is accepted on the following edge if still high.

## Configuration
- SERIAL_SUB_OVF_EN defined:
  - Port ovf exists.
  - ovf = (a[MSB] != b[MSB]) & (diff[MSB] != a[MSB]), evaluated on the captured operands and registered with diff.
  - Reset value 0.
- SERIAL_SUB_OVF_EN undefined: port ovf and its logic are absent. All other behaviour is identical.

## Test plan
- WIDTH=8, a=5, b=3, single start pulse → done high in the cycle after E8, diff=8'h02, borrow=0, busy high exactly 8 cycles.
- a=8'h00, b=8'h01 → diff=8'hFF, borrow=1; a=b=8'hA5 → diff=8'h00, borrow=0.
- start held high continuously, operands changed every cycle:
  - done pulses every 10 cycles.
  - Each result matches the operands present on its accepting edge only.
- Reset pulse at E4 of an operation with a=8'h10, b=8'h20:
  - No done pulse; all outputs 0.
  - Next start with a=9, b=4 gives diff=5 after 8 bit cycles.
- With SERIAL_SUB_OVF_EN:
  - a=8'h80, b=8'h01 → diff=8'h7F, borrow=0, ovf=1.
  - a=8'h7F, b=8'h01 → ovf=0.
  - Without the macro, the build has no ovf port.
- WIDTH=2, a=2'b01, b=2'b10 → diff=2'b11, borrow=1, done after E2.
